mem_access_unit: RTL and testbench

Load/store initiator sitting between the MIPS datapath's memory stage and the single-port word RAM. It accepts one byte, halfword or word access per request, drives the RAM's we/addr/din and consumes its dout, performs read-modify-write for sub-word stores and extracts/extends sub-word loads. Each request returns exactly one response pulse carrying load data or an error flag.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS load/store initiator for a single-port word RAM.
// Define MEM_ACCESS_CHECK_EN to reject misaligned, illegal-size and out-of-range requests.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LDCAP = 3'd3;
  localparam logic [2:0] S_MERGE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_err;
  logic [1:0]        size_eff;
  logic [1:0]        off_eff;

  // Request qualification: offsets are normalised here so later states never re-check alignment.
`ifdef MEM_ACCESS_CHECK_EN
  always_comb begin
    size_eff = req_size;
    off_eff  = req_addr[1:0];
    req_err  = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            || (|req_addr[31:ADDR_W+2]);
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_err  = 1'b0;
    size_eff = (req_size == 2'b11) ? 2'b10 : req_size;
    case (size_eff)
      2'b00:   off_eff = req_addr[1:0];
      2'b01:   off_eff = {req_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end
`endif

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    byte_sel = ram_dout[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      2'b01:   load_data = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_data = ram_dout;
    endcase
  end

  // Read-modify-write: only the addressed lane(s) take store data, the rest come back from RAM.
  always_comb begin
    merge_data = ram_dout;
    case (size_q)
      2'b00: merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (off_q[1]) merge_data[31:16] = wdata_q[15:0];
        else          merge_data[15:0]  = wdata_q[15:0];
      end
      default: merge_data = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = size_eff;
          signed_d   = req_signed;
          off_d      = off_eff;
          wdata_d    = req_wdata;
          ram_addr_d = req_addr[ADDR_W+1:2];
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (req_we && size_eff == 2'b10) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_READ: begin
        state_d = we_q ? S_MERGE : S_LDCAP;
      end
      S_LDCAP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_data;
      end
      S_MERGE: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'd0;
      ram_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Write enable comes straight from state so an asynchronous reset kills it immediately.
  assign ram_we    = (state_q == S_WRITE) || (state_q == S_MERGE);
  assign ram_din   = (state_q == S_MERGE) ? merge_data : wdata_q;
  assign ram_addr  = ram_addr_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a reference memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= ram[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(logic [1:0] size, logic [31:0] addr);
`ifdef MEM_ACCESS_CHECK_EN
    return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'h1000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] w, logic [1:0] size, logic sgn, logic [31:0] addr);
    int unsigned v;
    case (size)
      2'd0: begin
        v = (w >> (8 * addr[1:0])) & 32'hFF;
        if (sgn && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (16 * addr[1])) & 32'hFFFF;
        if (sgn && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_store(logic [31:0] w, logic [1:0] size, logic [31:0] addr, logic [31:0] wd);
    logic [31:0] m;
    case (size)
      2'd0: begin
        m = 32'hFF << (8 * addr[1:0]);
        return (w & ~m) | ((wd & 32'hFF) << (8 * addr[1:0]));
      end
      2'd1: begin
        m = 32'hFFFF << (16 * addr[1]);
        return (w & ~m) | ((wd & 32'hFFFF) << (16 * addr[1]));
      end
      default: return wd;
    endcase
  endfunction

  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int lat, we_cnt, we_cyc, ex_lat, ex_wecyc, ex_wecnt;
    logic [31:0] got_rd, ex_rd, idx;
    logic got_err, e;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom); req_size = 2'($urandom);
    lat = 0; we_cnt = 0; we_cyc = 0; got_rd = 32'hx; got_err = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ram_we) begin we_cnt++; we_cyc = c; end
      if (rsp_valid) begin lat = c; got_rd = rsp_rdata; got_err = rsp_err; break; end
    end
    e   = exp_err(size, addr);
    idx = {22'd0, addr[11:2]};
    if (e)                  begin ex_lat = 1; ex_wecnt = 0; ex_wecyc = 0; end
    else if (we && size[1]) begin ex_lat = 2; ex_wecnt = 1; ex_wecyc = 1; end
    else if (we)            begin ex_lat = 3; ex_wecnt = 1; ex_wecyc = 2; end
    else                    begin ex_lat = 3; ex_wecnt = 0; ex_wecyc = 0; end
    ex_rd = (e || we) ? 32'd0 : exp_load(ref_mem[idx], size, sgn, addr);
    chk({tag, "_latency"}, 32'(lat), 32'(ex_lat));
    chk({tag, "_rdata"}, got_rd, ex_rd);
    chk({tag, "_err"}, 32'(got_err), 32'(e));
    chk({tag, "_we_count"}, 32'(we_cnt), 32'(ex_wecnt));
    chk({tag, "_we_cycle"}, 32'(we_cyc), 32'(ex_wecyc));
    if (!e && we) ref_mem[idx] = exp_store(ref_mem[idx], size, addr, wdata);
  endtask

  initial begin
    logic [31:0] bdata [3];
    int acc [3];
    int k, npulse;
    logic [31:0] a, old24;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) access(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "preload");

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10");
    chk("lw10_const", rsp_rdata, 32'hDEADBEEF);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "sw10b");
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, "sb13");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10_sb");
    chk("lw10_sb_const", rsp_rdata, 32'hA5223344);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lb13");
    chk("lb13_const", rsp_rdata, 32'hFFFFFFA5);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lbu13");
    chk("lbu13_const", rsp_rdata, 32'h000000A5);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "sw10c");
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, "sh12");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10_sh");
    chk("lw10_sh_const", rsp_rdata, 32'h80013344);
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lh12");
    chk("lh12_const", rsp_rdata, 32'hFFFF8001);
    access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, "lhu10");
    chk("lhu10_const", rsp_rdata, 32'h00003344);

    access(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, "lw06");
    access(1'b0, 2'd1, 1'b1, 32'h03, 32'h0, "lh03");
    access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, "lw1000");
    access(1'b1, 2'd3, 1'b0, 32'h08, 32'h5A5A1234, "size11");

    // Back-to-back word stores with req_valid held high throughout.
    for (int i = 0; i < 3; i++) bdata[i] = $urandom;
    k = 0; npulse = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (rsp_valid) npulse++;
      if (k < 3) begin
        if (req_ready) begin
          req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
          req_addr = 32'(k * 4); req_wdata = bdata[k];
          acc[k] = c; k++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd2);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd2);
    chk("b2b_pulses", 32'(npulse), 32'd3);
    for (int i = 0; i < 3; i++) ref_mem[i] = bdata[i];
    for (int i = 0; i < 3; i++) access(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, "b2b_rd");

    // Reset while the sub-word store is still reading.
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, "sw20");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rrd_ready", 32'(req_ready), 32'd1);
    chk("rrd_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rrd_rdata", rsp_rdata, 32'd0);
    chk("rrd_err", 32'(rsp_err), 32'd0);
    chk("rrd_ram_we", 32'(ram_we), 32'd0);
    chk("rrd_ram_addr", 32'(ram_addr), 32'd0);
    chk("rrd_ram_din", ram_din, 32'd0);
    npulse = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid || ram_we) npulse++; end
    chk("rrd_quiet", 32'(npulse), 32'd0);
    rst_n = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "rrd_lw20");
    chk("rrd_lw20_const", rsp_rdata, 32'hCAFEF00D);

    // Reset during a word write must drop ram_we before the write edge.
    old24 = ref_mem[9];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = ~old24;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rwr_we_before", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rwr_we_after", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, "rwr_lw24");
    chk("rwr_lw24_old", rsp_rdata, old24);

    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
